vram_dma_ctrl: RTL and testbench

Sequences character-row fetches from the shared SRAM into a line FIFO for the CRTC video pipeline. On each row request it raises a bus request to the Z80 core, waits for bus acknowledge, bursts a fixed number of sequential reads from the SRAM, and buffers the returned bytes. It sits between the CPU bus-grant handshake, the SRAM address mux and the CRTC character/attribute decoder. It is the single owner of `busreq` and the DMA half of the SRAM address mux.

---
 rtl/vram_dma_ctrl_pkg.sv | 21 ++
 rtl/vram_dma_ctrl_line_fifo.sv | 68 ++++++
 rtl/vram_dma_ctrl.sv | 172 +++++++++++++++++
 tb/tb_vram_dma_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_dma_ctrl_pkg.sv
// rtl/vram_dma_ctrl_pkg.sv - shared state encodings and default sizing for the VRAM DMA controller
//
// Purpose: single home for the controller state encoding and the default
//          row/FIFO geometry so the top and its sub-module agree.
// Ports:   none (package).
package vram_dma_ctrl_pkg;

  localparam int DEF_ROW_BYTES  = 120;  // 80 text + 40 attribute bytes
  localparam int DEF_FIFO_DEPTH = 128;
  localparam int DEF_AW         = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAITSPACE = 3'd1,
    ST_REQ       = 3'd2,
    ST_BURST     = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_RELEASE   = 3'd5
  } state_e;

endpackage

// File: rtl/vram_dma_ctrl_line_fifo.sv
// rtl/vram_dma_ctrl_line_fifo.sv - first-word-fall-through byte FIFO holding one or more character rows
//
// Purpose: synchronous FWFT FIFO, 8-bit wide, DEPTH entries (power of two).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (flushes pointers)
//   push, din      write one byte
//   pop            read one byte; ignored when empty
//   dout           head of FIFO (0 while empty)
//   empty, level   registered status, updated the cycle after push/pop
//   underrun       combinational pulse: pop requested while empty
module vram_dma_ctrl_line_fifo #(
  parameter  int DEPTH = 128,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          underrun
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          pop_ok;

  always_comb begin
    pop_ok   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    level_d  = level_q + LW'(push) - LW'(pop_ok);
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Storage is not reset, so mask the head while empty to give a defined 0.
  assign dout     = empty_q ? 8'h00 : mem[rd_ptr_q];
  assign empty    = empty_q;
  assign level    = level_q;
  assign underrun = pop && empty_q;

endmodule

// File: rtl/vram_dma_ctrl.sv
// rtl/vram_dma_ctrl.sv - character-row DMA from shared SRAM into the CRTC line FIFO
//
// Purpose: on each row request, take the CPU bus (busreq/busack), burst
//          ROW_BYTES sequential SRAM reads and buffer the bytes in a line FIFO.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   base_addr, frame_start  frame base; pulse reloads the row pointer at next row start
//   row_req                 pulse: fetch one row (one request may be held pending)
//   busreq, busack          CPU bus request / acknowledge
//   ram_adr, ram_data       DMA read address, SRAM data (one-cycle latency)
//   fifo_rd, fifo_dout      FIFO pop and FWFT head
//   fifo_empty, fifo_level  FIFO status
//   busy                    controller not idle
//   overrun, underrun       sticky error flags, cleared only by reset
module vram_dma_ctrl
  import vram_dma_ctrl_pkg::*;
#(
  parameter  int ROW_BYTES  = DEF_ROW_BYTES,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int AW         = DEF_AW,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] base_addr,
  input  logic          frame_start,
  input  logic          row_req,
  output logic          busreq,
  input  logic          busack,
  output logic [AW-1:0] ram_adr,
  input  logic [7:0]    ram_data,
  input  logic          fifo_rd,
  output logic [7:0]    fifo_dout,
  output logic          fifo_empty,
  output logic [LW-1:0] fifo_level,
  output logic          busy,
  output logic          overrun,
  output logic          underrun
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          issued_q, issued_d;
  logic          pending_q, pending_d;
  logic          reload_q, reload_d;
  logic          busreq_q, busreq_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;

  logic [LW-1:0] free_space;
  logic          space_ok;
  logic          issue;
  logic          last_issue;
  logic          leave_idle;
  logic          fifo_underrun;

  assign free_space = LW'(FIFO_DEPTH) - fifo_level;
  assign space_ok   = (free_space >= LW'(ROW_BYTES));
  assign issue      = (state_q == ST_BURST) && busack;
  assign last_issue = (cnt_q == LW'(ROW_BYTES - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      issued_q   <= 1'b0;
      pending_q  <= 1'b0;
      reload_q   <= 1'b0;
      busreq_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      pending_q  <= pending_d;
      reload_q   <= reload_d;
      busreq_q   <= busreq_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (row_req || pending_q) state_d = ST_WAITSPACE;
      ST_WAITSPACE: if (space_ok)             state_d = ST_REQ;
      ST_REQ:       if (busack)               state_d = ST_BURST;
      ST_BURST:     if (issue && last_issue)  state_d = ST_DRAIN;
      ST_DRAIN:                               state_d = ST_RELEASE;
      ST_RELEASE:   if (!busack)              state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    leave_idle = (state_q == ST_IDLE) && (state_d == ST_WAITSPACE);

    // ptr_q doubles as ram_adr: it holds the address being issued in each
    // BURST cycle, so the first address is on the bus as soon as BURST starts.
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (leave_idle && (reload_q || frame_start)) begin
      ptr_d = base_addr;
    end
    if (state_q == ST_REQ) begin
      cnt_d = '0;
    end
    if (issue) begin
      ptr_d = ptr_q + AW'(1);
      cnt_d = cnt_q + LW'(1);
    end
    issued_d = issue;

    // A frame_start coinciding with the row start is consumed immediately.
    reload_d = reload_q;
    if (leave_idle) begin
      reload_d = 1'b0;
    end else if (frame_start) begin
      reload_d = 1'b1;
    end

    // IDLE always leaves when pending is set, so IDLE consumes the flag.
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (state_q == ST_IDLE) begin
      pending_d = 1'b0;
    end else if (row_req) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    busreq_d   = (state_d == ST_REQ) || (state_d == ST_BURST) || (state_d == ST_DRAIN);
    busy_d     = (state_d != ST_IDLE);
    underrun_d = underrun_q || fifo_underrun;
  end

  // ram_data for an issued address arrives the cycle after issue.
  vram_dma_ctrl_line_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (issued_q),
    .pop      (fifo_rd),
    .din      (ram_data),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .underrun (fifo_underrun)
  );

  assign busreq   = busreq_q;
  assign ram_adr  = ptr_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vram_dma_ctrl.sv
// tb/tb_vram_dma_ctrl.sv - directed self-checking bench for vram_dma_ctrl
//
// Purpose: drives row fetches through a CPU grant model and an SRAM model,
//          then checks bus timing, FIFO contents and error flags.
// Ports:   none (top-level bench).
module tb_vram_dma_ctrl;

  localparam int ROW       = 120;
  localparam int ACK_DELAY = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] base_addr;
  logic        frame_start;
  logic        row_req;
  logic        busreq;
  logic        busack;
  logic [15:0] ram_adr;
  logic [7:0]  ram_data;
  logic        fifo_rd;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic [7:0]  fifo_level;
  logic        busy;
  logic        overrun;
  logic        underrun;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int          issue_cnt = 0;
  int          seen      = 0;
  int          gap       = 0;
  int          glitch_at = 0;
  bit          drop_pending = 1'b0;
  logic [15:0] first_adr = 16'h0;

  always #5 clk = ~clk;

  vram_dma_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .base_addr   (base_addr),
    .frame_start (frame_start),
    .row_req     (row_req),
    .busreq      (busreq),
    .busack      (busack),
    .ram_adr     (ram_adr),
    .ram_data    (ram_data),
    .fifo_rd     (fifo_rd),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  function automatic logic [7:0] mdl(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // SRAM: one-cycle synchronous read.
  always @(posedge clk) ram_data <= mdl(ram_adr);

  // CPU grant model: acks ACK_DELAY cycles after busreq, counts issue cycles,
  // and can withdraw busack for 4 cycles after issue number glitch_at.
  always @(negedge clk) begin
    if (!reset_n) begin
      busack = 1'b0; seen = 0; gap = 0; drop_pending = 1'b0; issue_cnt = 0;
    end else if (!busreq) begin
      busack = 1'b0; seen = 0; gap = 0; drop_pending = 1'b0; issue_cnt = 0;
    end else if (!busack) begin
      if (gap > 0) begin
        gap--;
        if (gap == 0) begin busack = 1'b1; issue_cnt++; end
      end else begin
        seen++;
        if (seen > ACK_DELAY) begin busack = 1'b1; issue_cnt = 0; end
      end
    end else if (drop_pending) begin
      busack = 1'b0; gap = 4; drop_pending = 1'b0;
    end else if (issue_cnt < ROW) begin
      issue_cnt++;
      if (issue_cnt == 1) first_adr = ram_adr;
      if (glitch_at != 0 && issue_cnt == glitch_at) drop_pending = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_row();
    row_req = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, output int hi);
    int g;
    g  = 0;
    hi = 0;
    while (busy === 1'b1 && g < 3000) begin
      if (busreq === 1'b1) hi++;
      @(negedge clk);
      g++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Pops n bytes (waiting while empty) and compares them to the SRAM model.
  task automatic pop_check(input string tag, input logic [15:0] start, input int n);
    int          got;
    int          errs;
    int          g;
    logic [15:0] a;
    got  = 0;
    errs = 0;
    g    = 0;
    while (got < n && g < 5000) begin
      if (fifo_empty === 1'b0) begin
        a = start + 16'(got);
        if (fifo_dout !== mdl(a)) errs++;
        fifo_rd = 1'b1;
        got++;
      end else begin
        fifo_rd = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    fifo_rd = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_data_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int hi;
    int g;
    reset_n     = 1'b0;
    base_addr   = 16'h0;
    frame_start = 1'b0;
    row_req     = 1'b0;
    fifo_rd     = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busreq",   32'(busreq),     32'd0);
    check("rst_ram_adr",  32'(ram_adr),    32'd0);
    check("rst_dout",     32'(fifo_dout),  32'd0);
    check("rst_empty",    32'(fifo_empty), 32'd1);
    check("rst_level",    32'(fifo_level), 32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_overrun",  32'(overrun),    32'd0);
    check("rst_underrun", 32'(underrun),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic row: frame_start then row_req, grant 3 cycles after busreq.
    base_addr   = 16'hF300;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pulse_row();
    check("basic_busy_n1",   32'(busy),   32'd1);
    check("basic_busreq_n1", 32'(busreq), 32'd0);
    @(negedge clk);
    check("basic_busreq_n2", 32'(busreq), 32'd1);
    run_until_idle("basic", hi);
    check("basic_busreq_cycles", 32'(hi), 32'(ACK_DELAY + 1 + ROW + 1));
    check("basic_first_adr", 32'(first_adr), 32'hF300);
    check("basic_level", 32'(fifo_level), 32'(ROW));
    pop_check("basic", 16'hF300, ROW);
    check("basic_empty_after", 32'(fifo_empty), 32'd1);

    // Wrap: frame_start and row_req in the same idle cycle.
    base_addr   = 16'hFFF0;
    frame_start = 1'b1;
    row_req     = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    row_req     = 1'b0;
    run_until_idle("wrap", hi);
    check("wrap_busreq_cycles", 32'(hi), 32'(ACK_DELAY + 1 + ROW + 1));
    check("wrap_ptr_after", 32'(ram_adr), 32'h0068);
    pop_check("wrap", 16'hFFF0, ROW);

    // Backpressure: pointer continues at 0068h; leave 10 bytes in the FIFO.
    pulse_row();
    run_until_idle("bp_fill", hi);
    pop_check("bp_prefill", 16'h0068, 110);
    check("bp_level10", 32'(fifo_level), 32'd10);
    pulse_row();
    repeat (6) @(negedge clk);
    check("bp_wait_busreq", 32'(busreq),     32'd0);
    check("bp_wait_busy",   32'(busy),       32'd1);
    check("bp_wait_level",  32'(fifo_level), 32'd10);
    pop_check("bp_pop2", 16'h00D6, 2);
    run_until_idle("bp_burst", hi);
    check("bp_busreq_cycles", 32'(hi), 32'(ACK_DELAY + 1 + ROW + 1));
    check("bp_level_full", 32'(fifo_level), 32'd128);
    check("bp_not_empty",  32'(fifo_empty), 32'd0);
    pop_check("bp_all", 16'h00D8, 128);

    // Grant glitch: busack withdrawn for 4 cycles after the 50th issue.
    glitch_at   = 50;
    base_addr   = 16'h1000;
    frame_start = 1'b1;
    row_req     = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    row_req     = 1'b0;
    run_until_idle("glitch", hi);
    glitch_at = 0;
    check("glitch_busreq_cycles", 32'(hi), 32'(ACK_DELAY + 1 + ROW + 4 + 1));
    check("glitch_level", 32'(fifo_level), 32'(ROW));
    pop_check("glitch", 16'h1000, ROW);
    check("glitch_no_overrun", 32'(overrun), 32'd0);

    // Overrun: three extra requests during one burst -> two rows total.
    base_addr   = 16'h2000;
    frame_start = 1'b1;
    row_req     = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    row_req     = 1'b0;
    repeat (10) @(negedge clk);
    pulse_row();
    repeat (10) @(negedge clk);
    check("ovr_pending_only", 32'(overrun), 32'd0);
    pulse_row();
    repeat (10) @(negedge clk);
    pulse_row();
    @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    pop_check("ovr_rows", 16'h2000, 2 * ROW);
    run_until_idle("ovr", hi);
    repeat (10) @(negedge clk);
    check("ovr_no_third_busy",  32'(busy),       32'd0);
    check("ovr_no_third_level", 32'(fifo_level), 32'd0);

    // Underrun: pop on empty.
    check("unr_before", 32'(underrun), 32'd0);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    @(negedge clk);
    check("unr_flag",  32'(underrun),   32'd1);
    check("unr_level", 32'(fifo_level), 32'd0);
    check("unr_empty", 32'(fifo_empty), 32'd1);

    // Reset mid-burst at the 30th issue.
    base_addr   = 16'h3000;
    frame_start = 1'b1;
    row_req     = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    row_req     = 1'b0;
    g = 0;
    while (issue_cnt < 30 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("mid_reached_issue30", 32'(issue_cnt >= 30), 32'd1);
    check("mid_busreq_before", 32'(busreq), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("mid_busreq_async", 32'(busreq), 32'd0);
    @(negedge clk);
    check("mid_ram_adr",  32'(ram_adr),    32'd0);
    check("mid_dout",     32'(fifo_dout),  32'd0);
    check("mid_empty",    32'(fifo_empty), 32'd1);
    check("mid_level",    32'(fifo_level), 32'd0);
    check("mid_busy",     32'(busy),       32'd0);
    check("mid_overrun",  32'(overrun),    32'd0);
    check("mid_underrun", 32'(underrun),   32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_busreq", 32'(busreq),     32'd0);
    check("post_level",  32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
